decode_issue: RTL and testbench
===============================

# decode_issue

Decode-and-issue stage sitting directly upstream of the ALU. It accepts 16-bit instructions over a valid/ready handshake and reads operands from its own 16×16 register file. It registers `A`, `B`, `op`, `imm` and `FlagEn` into the ALU each cycle, and writes the ALU's registered result back into the register file. It also detects read-after-write hazards on in-flight results and resolves them by stalling and/or bypassing.

## Interface
Parameters:
- `DSIZE`, 16 (from `define.v`): data width.
- `NREG`, 16: register count; R0 reads zero.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  **asynchronous, active-low reset**; one clock domain.
- `instr`  in  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt or imm.
- `instr_valid`  in  1  `instr` is presented.
- `instr_ready`  out  1  stage accepts `instr` this cycle.
- `alu_out`  in  DSIZE  ALU registered result.
- `alu_flag`  in  3  ALU registered flags {n,v,z}.
- `A`, `B`  out  DSIZE  ALU operands (registered).
- `op`  out  3  ALU opcode (registered).
- `imm`  out  4  shift amount (registered).
- `FlagEn`  out  1  flag update enable (registered).
- `lastFlag`  out  3  equals `alu_flag`, combinational pass-through.
- `err`  out  1  sticky: a reserved opcode was accepted.

## Operation
Decode:
- Opcode 0–3 (ADD, SUB, AND, OR): `A`=R[rs], `B`=R[rt], `imm`=0, `FlagEn`=1.
- Opcode 4–7 (SLL, SRL, SRA, RL): `A`=R[rs], `B`=0, `imm`=instr[3:0], `FlagEn`=0.
- Opcode 8–15 is reserved: it is accepted and consumed, a bubble is issued, and `err` is set until reset.

Bubble:
- `op`=ADD, `A`=`B`=0, `imm`=0, `FlagEn`=0.
- Issued whenever no instruction is accepted.
- Never produces a writeback.

Tracking pipeline:
- `ex_v`/`ex_rd` describe the instruction currently held in the ALU input registers.
- `wb_v`/`wb_rd` describe the instruction whose result is now on `alu_out`.
- Each cycle `wb` ← `ex` and `ex` ← the issued instruction; a bubble or rd=0 sets valid=0.

Writeback:
- When `wb_v`, R[wb_rd] ← `alu_out` at the clock edge.
- Writes to R0 are discarded.

Operand read for a source s (rs, or rt for opcodes 0–3), when s≠0:
- Hazard (stall): `ex_v` and s==`ex_rd`.
- Bypass: `wb_v` and s==`wb_rd` → operand = `alu_out`. This takes priority over the register file, including the same-edge write.
- Otherwise: operand = R[s].

Handshake:
- `instr_ready` = ~stall, combinational from `instr` and the ex/wb state.
- A transfer occurs when `instr_valid` & `instr_ready`.
- While stalled: a bubble is issued, the held instruction is not consumed, and the producer must hold `instr` stable.
- `instr_valid`=0 → bubble, `instr_ready`=1.
- rd is irrelevant to hazards except through `ex_rd`/`wb_rd`. WAW needs no check because writeback is in order.

## Timing
Reset (asynchronous, on `rst_n` low):
- `A`, `B`, `op`, `imm`, `FlagEn` = 0.
- `ex_v`, `wb_v` = 0; `err` = 0; all registers = 0.
- `instr_ready` = 1 once `rst_n` is high.
- Reset mid-stream drops all in-flight results: no writeback occurs after reset release.

Latency:
- Instruction accepted at edge k: ALU inputs valid after k, `alu_out` valid after k+1, register file updated at k+2.

Dependencies:
- Back-to-back dependent instructions: 1 stall cycle, then issue at k+2 with the bypass from `alu_out`.
- Dependency at distance 2: no stall (bypass).
- Dependency at distance ≥3: read from the register file.

Simultaneous events:
- A stall and a writeback in the same cycle: the writeback proceeds.
- A stall with `instr_valid` dropping: legal only after a transfer; the producer must not withdraw an unaccepted instruction.

## Configuration
- `DECODE_ISSUE_FWD_EN` defined: bypass enabled exactly as above.
- Undefined: no bypass; operands come only from the register file. The stall condition becomes (`ex_v` & s==`ex_rd`) | (`wb_v` & s==`wb_rd`).
  - Back-to-back dependency stalls 2 cycles.
  - Distance-2 dependency stalls 1 cycle.
  - Results are identical; only timing differs.

## Test plan
- Reset, then issue ADD R1,R0,R0 with R0=0 → `A`=`B`=0, `FlagEn`=1; R1=0 after 2 cycles; `instr_ready` stays 1.
- Preload R2=5, R3=7 via ADD/SLL chains. Issue ADD R4,R2,R3 followed immediately by SUB R5,R4,R2 → `instr_ready` low exactly 1 cycle and SUB issues with `A`=12, `B`=5. Without FWD_EN: 2 cycles low, same values.
- ADD R4,R2,R3; OR R6,R0,R0; AND R7,R4,R4 → no stall; AND issues `A`=`B`=12 via bypass.
- SLL R1,R2,imm=3 with R2=5 → `op`=SLL, `imm`=3, `B`=0, `FlagEn`=0; R1=40.
- Opcode 0xA accepted → bubble issued, `err`=1 and stays 1; next valid instruction issues normally.
- Assert `rst_n` low while ADD R4 is in the ex slot → after release R4=0, outputs 0, no writeback.

Source files
------------

// File: rtl/decode_issue_if.sv
// Handshake and ALU-side bus between the instruction producer/ALU and decode_issue.
interface decode_issue_if #(parameter int DSIZE = 16);
   logic [15:0]      instr;
   logic             instr_valid;
   logic             instr_ready;
   logic [DSIZE-1:0] alu_out;
   logic [2:0]       alu_flag;
   logic [DSIZE-1:0] A;
   logic [DSIZE-1:0] B;
   logic [2:0]       op;
   logic [3:0]       imm;
   logic             FlagEn;
   logic [2:0]       lastFlag;
   logic             err;

   modport master (
      output instr, instr_valid, alu_out, alu_flag,
      input  instr_ready, A, B, op, imm, FlagEn, lastFlag, err
   );

   modport slave (
      input  instr, instr_valid, alu_out, alu_flag,
      output instr_ready, A, B, op, imm, FlagEn, lastFlag, err
   );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage with local register file, RAW hazard stall and optional bypass.
// Define DECODE_ISSUE_FWD_EN to bypass alu_out into operands; otherwise stall until writeback.
module decode_issue #(
   parameter int DSIZE = 16,
   parameter int NREG  = 16
) (
   input logic           clk,
   input logic           rst_n,
   decode_issue_if.slave bus_if
);
   localparam logic [2:0] OP_ADD = 3'd0;

   logic [DSIZE-1:0] rf_q [NREG];
   logic [DSIZE-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [3:0]       imm_q, imm_d;
   logic             flag_en_q, flag_en_d;
   logic             ex_v_q, ex_v_d, wb_v_q;
   logic [3:0]       ex_rd_q, ex_rd_d, wb_rd_q;
   logic             err_q, err_d;

   logic [3:0]       opc, rd, rs, rt;
   logic             is_rsv, uses_rt;
   logic             haz_rs, haz_rt, stall, accept, issue;
   logic [DSIZE-1:0] opnd_rs, opnd_rt;

   always_comb begin
      opc     = bus_if.instr[15:12];
      rd      = bus_if.instr[11:8];
      rs      = bus_if.instr[7:4];
      rt      = bus_if.instr[3:0];
      is_rsv  = opc[3];
      uses_rt = (opc[3:2] == 2'b00);

      haz_rs = (rs != 4'd0) && ex_v_q && (rs == ex_rd_q);
      haz_rt = uses_rt && (rt != 4'd0) && ex_v_q && (rt == ex_rd_q);
`ifndef DECODE_ISSUE_FWD_EN
      // Without bypass the result is only usable once it lands in the register file.
      haz_rs = haz_rs || ((rs != 4'd0) && wb_v_q && (rs == wb_rd_q));
      haz_rt = haz_rt || (uses_rt && (rt != 4'd0) && wb_v_q && (rt == wb_rd_q));
`endif
      // Reserved opcodes read no operands, so they never wait on a hazard.
      stall  = bus_if.instr_valid && !is_rsv && (haz_rs || haz_rt);
      accept = bus_if.instr_valid && !stall;
      issue  = accept && !is_rsv;
   end

   always_comb begin
      opnd_rs = rf_q[rs];
      opnd_rt = rf_q[rt];
`ifdef DECODE_ISSUE_FWD_EN
      // Bypass beats the register file, including the write landing on this same edge.
      if (wb_v_q && (rs != 4'd0) && (rs == wb_rd_q)) opnd_rs = bus_if.alu_out;
      if (wb_v_q && (rt != 4'd0) && (rt == wb_rd_q)) opnd_rt = bus_if.alu_out;
`endif
   end

   always_comb begin
      a_d       = issue ? opnd_rs : '0;
      b_d       = (issue && uses_rt) ? opnd_rt : '0;
      op_d      = issue ? opc[2:0] : OP_ADD;
      imm_d     = (issue && !uses_rt) ? rt : 4'd0;
      flag_en_d = issue && uses_rt;
      ex_v_d    = issue && (rd != 4'd0);
      ex_rd_d   = ex_v_d ? rd : 4'd0;
      err_d     = err_q || (accept && is_rsv);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
         imm_q     <= 4'd0;
         flag_en_q <= 1'b0;
         ex_v_q    <= 1'b0;
         ex_rd_q   <= 4'd0;
         wb_v_q    <= 1'b0;
         wb_rd_q   <= 4'd0;
         err_q     <= 1'b0;
      end else begin
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         imm_q     <= imm_d;
         flag_en_q <= flag_en_d;
         ex_v_q    <= ex_v_d;
         ex_rd_q   <= ex_rd_d;
         wb_v_q    <= ex_v_q;
         wb_rd_q   <= ex_rd_q;
         err_q     <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_v_q && (wb_rd_q != 4'd0)) begin
         rf_q[wb_rd_q] <= bus_if.alu_out;
      end
   end

   assign bus_if.instr_ready = !stall;
   assign bus_if.A           = a_q;
   assign bus_if.B           = b_q;
   assign bus_if.op          = op_q;
   assign bus_if.imm         = imm_q;
   assign bus_if.FlagEn      = flag_en_q;
   assign bus_if.lastFlag    = bus_if.alu_flag;
   assign bus_if.err         = err_q;
endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: vector table plus scoreboard, with a small registered ALU model.
module tb_decode_issue;
`ifdef DECODE_ISSUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_issue_if #(.DSIZE(16)) bus();
   decode_issue #(.DSIZE(16), .NREG(16)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

   typedef struct {
      logic [15:0] ins;
      logic        vld;
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
      logic [3:0]  imm;
      logic        fe;
      logic        err;
      int          st_fwd;
      int          st_nof;
      logic        inj;
      logic [15:0] ival;
   } vec_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
      logic [3:0]  imm;
      logic        fe;
      logic        err;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

   // ALU model; inj_v lets the bench force a result to seed register values.
   logic        inj_v = 1'b0;
   logic [15:0] inj_val = 16'h0;

   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op, input logic [3:0] sh);
      logic [31:0] rot;
      rot = {a, a} << sh;
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a << sh;
         3'd5: return a >> sh;
         3'd6: return 16'($signed(a) >>> sh);
         default: return rot[31:16];
      endcase
   endfunction

   function automatic logic [2:0] flg_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op, input logic [15:0] r);
      logic v;
      v = 1'b0;
      if (op == 3'd0) v = (a[15] == b[15]) && (r[15] != a[15]);
      if (op == 3'd1) v = (a[15] != b[15]) && (r[15] != a[15]);
      return {r[15], v, (r == 16'h0)};
   endfunction

   always @(posedge clk) begin
      logic [15:0] r;
      r = inj_v ? inj_val : alu_f(bus.A, bus.B, bus.op, bus.imm);
      bus.alu_out  <= r;
      bus.alu_flag <= flg_f(bus.A, bus.B, bus.op, r);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      inj_v = 1'b0;
   endtask

   function automatic vec_t mk(input logic [15:0] ins, input logic vld,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] op, input logic [3:0] imm,
                               input logic fe, input logic err,
                               input int stf, input int stn,
                               input logic inj, input logic [15:0] ival);
      vec_t v;
      v.ins = ins; v.vld = vld; v.a = a; v.b = b; v.op = op; v.imm = imm;
      v.fe = fe; v.err = err; v.st_fwd = stf; v.st_nof = stn; v.inj = inj; v.ival = ival;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      exp_t g;
      int   st;
      int   exp_st;
      bus.instr       = v.ins;
      bus.instr_valid = v.vld;
      exp_st = FWD ? v.st_fwd : v.st_nof;
      st = 0;
      @(negedge clk);
      chk($sformatf("v%0d_lastFlag", idx), 32'(bus.lastFlag), 32'(bus.alu_flag));
      while (!bus.instr_ready && st < 8) begin
         st++;
         tick();
         chk($sformatf("v%0d_stall_bubble", idx), {bus.A, bus.B}, 32'h0);
         chk($sformatf("v%0d_stall_fe", idx), 32'(bus.FlagEn), 32'h0);
         @(negedge clk);
      end
      if (!bus.instr_ready) begin
         chk($sformatf("v%0d_ready_timeout", idx), 32'(bus.instr_ready), 32'h1);
         bus.instr_valid = 1'b0;
         return;
      end
      e.a = v.a; e.b = v.b; e.op = v.op; e.imm = v.imm; e.fe = v.fe; e.err = v.err;
      sb.push_back(e);
      tick();
      inj_v   = v.inj;
      inj_val = v.ival;
      g = sb.pop_front();
      chk($sformatf("v%0d_A", idx), 32'(bus.A), 32'(g.a));
      chk($sformatf("v%0d_B", idx), 32'(bus.B), 32'(g.b));
      chk($sformatf("v%0d_op", idx), 32'(bus.op), 32'(g.op));
      chk($sformatf("v%0d_imm", idx), 32'(bus.imm), 32'(g.imm));
      chk($sformatf("v%0d_FlagEn", idx), 32'(bus.FlagEn), 32'(g.fe));
      chk($sformatf("v%0d_err", idx), 32'(bus.err), 32'(g.err));
      chk($sformatf("v%0d_stalls", idx), 32'(st), 32'(exp_st));
   endtask

   initial begin
      vec_t idle0;
      vec_t idle1;
      idle0 = mk(16'h0000, 1'b0, 16'd0, 16'd0, 3'd0, 4'd0, 1'b0, 1'b0, 0, 0, 1'b0, 16'd0);
      idle1 = mk(16'h0000, 1'b0, 16'd0, 16'd0, 3'd0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0, 16'd0);

      vt.push_back(mk(16'h0100, 1'b1, 16'd0,  16'd0,  3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h0200, 1'b1, 16'd0,  16'd0,  3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b1, 16'd5));
      vt.push_back(mk(16'h0300, 1'b1, 16'd0,  16'd0,  3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b1, 16'd7));
      repeat (3) vt.push_back(idle0);
      vt.push_back(mk(16'h0423, 1'b1, 16'd5,  16'd7,  3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h1542, 1'b1, 16'd12, 16'd5,  3'd1, 4'd0, 1'b1, 1'b0, 1, 2, 1'b0, 16'd0));
      repeat (3) vt.push_back(idle0);
      vt.push_back(mk(16'h0423, 1'b1, 16'd5,  16'd7,  3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h3600, 1'b1, 16'd0,  16'd0,  3'd3, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h2744, 1'b1, 16'd12, 16'd12, 3'd2, 4'd0, 1'b1, 1'b0, 0, 1, 1'b0, 16'd0));
      vt.push_back(mk(16'h4123, 1'b1, 16'd5,  16'd0,  3'd4, 4'd3, 1'b0, 1'b0, 0, 0, 1'b0, 16'd0));
      repeat (3) vt.push_back(idle0);
      vt.push_back(mk(16'h0810, 1'b1, 16'd40, 16'd0,  3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h6981, 1'b1, 16'd40, 16'd0,  3'd6, 4'd1, 1'b0, 1'b0, 1, 2, 1'b0, 16'd0));
      vt.push_back(mk(16'hA000, 1'b1, 16'd0,  16'd0,  3'd0, 4'd0, 1'b0, 1'b1, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h7A94, 1'b1, 16'd20, 16'd0,  3'd7, 4'd4, 1'b0, 1'b1, 0, 1, 1'b0, 16'd0));
      vt.push_back(mk(16'h5B52, 1'b1, 16'd7,  16'd0,  3'd5, 4'd2, 1'b0, 1'b1, 0, 0, 1'b0, 16'd0));
      vt.push_back(mk(16'h1C75, 1'b1, 16'd12, 16'd7,  3'd1, 4'd0, 1'b1, 1'b1, 0, 0, 1'b0, 16'd0));
      vt.push_back(idle1);

      bus.instr       = 16'h0;
      bus.instr_valid = 1'b0;
      #2;
      chk("rst_AB", {bus.A, bus.B}, 32'h0);
      chk("rst_op_imm", {25'h0, bus.op, bus.imm}, 32'h0);
      chk("rst_FlagEn", 32'(bus.FlagEn), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      chk("rst_ready", 32'(bus.instr_ready), 32'h1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

      // Reset while ADD R4 sits in the ex slot; alu_out is forced non-zero so any stale writeback shows.
      run_vec(mk(16'h0423, 1'b1, 16'd5, 16'd7, 3'd0, 4'd0, 1'b1, 1'b1, 0, 0, 1'b0, 16'd0), 100);
      bus.instr_valid = 1'b0;
      rst_n   = 1'b0;
      inj_v   = 1'b1;
      inj_val = 16'h0055;
      #1;
      chk("midrst_AB", {bus.A, bus.B}, 32'h0);
      chk("midrst_FlagEn", 32'(bus.FlagEn), 32'h0);
      chk("midrst_err", 32'(bus.err), 32'h0);
      chk("midrst_ready", 32'(bus.instr_ready), 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("postrst_AB", {bus.A, bus.B}, 32'h0);
      chk("postrst_op", 32'(bus.op), 32'h0);
      inj_v = 1'b0;
      run_vec(mk(16'h0540, 1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0), 101);
      run_vec(mk(16'h0623, 1'b1, 16'd0, 16'd0, 3'd0, 4'd0, 1'b1, 1'b0, 0, 0, 1'b0, 16'd0), 102);
      run_vec(idle0, 103);

      bus.instr_valid = 1'b0;
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
